// File: rtl/vc_pkg.sv
// Shared definitions for the VC dispatch stage: FSM encoding, VC indices and
// statistics counter width.
package vc_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } vc_state_t;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  localparam int STATS_W = 8;

endpackage

// File: rtl/vc_dispatch_stats.sv
// Pair of saturating push counters, one per virtual channel.
// Only instantiated when VC_DISPATCH_STATS_EN is defined.
module vc_dispatch_stats
  import vc_pkg::*;
(
  input  logic               clk,
  input  logic               reset_L,
  input  logic               i_push_vc0,
  input  logic               i_push_vc1,
  output logic [STATS_W-1:0] o_cnt_vc0,
  output logic [STATS_W-1:0] o_cnt_vc1
);

  localparam logic [STATS_W-1:0] CNT_MAX = '1;

  logic [STATS_W-1:0] r_cnt_vc0;
  logic [STATS_W-1:0] r_cnt_vc1;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_cnt_vc0 <= '0;
      r_cnt_vc1 <= '0;
    end else begin
      if (i_push_vc0 && (r_cnt_vc0 != CNT_MAX)) r_cnt_vc0 <= r_cnt_vc0 + 1'b1;
      if (i_push_vc1 && (r_cnt_vc1 != CNT_MAX)) r_cnt_vc1 <= r_cnt_vc1 + 1'b1;
    end
  end

  assign o_cnt_vc0 = r_cnt_vc0;
  assign o_cnt_vc1 = r_cnt_vc1;

endmodule

// File: rtl/vc_dispatch.sv
// Main-FIFO to virtual-channel dispatcher with a one-word hold register for late
// back-pressure. Optional push counters are enabled by VC_DISPATCH_STATS_EN.
module vc_dispatch
  import vc_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int VC_BIT    = DATA_SIZE - 1
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 fifo_empty_main,
  input  logic [DATA_SIZE-1:0] data_demux_vc,
  input  logic                 pause_vc0,
  input  logic                 pause_vc1,
  input  logic                 full_vc0,
  input  logic                 full_vc1,
  output logic                 pop_main,
  output logic                 push_vc0,
  output logic                 push_vc1,
  output logic [DATA_SIZE-1:0] data_vc0,
  output logic [DATA_SIZE-1:0] data_vc1,
  output logic                 dispatch_idle
`ifdef VC_DISPATCH_STATS_EN
  ,
  output logic [STATS_W-1:0]   cnt_vc0,
  output logic [STATS_W-1:0]   cnt_vc1
`endif
);

  vc_state_t            r_state;
  vc_state_t            w_next_state;
  logic                 r_fetch;
  logic [DATA_SIZE-1:0] r_hold;

  logic                 w_sel;
  logic                 w_hold_sel;
  logic                 w_arr_full;
  logic                 w_hold_full;
  logic                 w_stall;
  logic                 w_release;
  logic                 w_hold_load;
  logic                 w_push0;
  logic                 w_push1;
  logic [DATA_SIZE-1:0] w_push_word;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= ST_RUN;
      r_fetch <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next_state;
      r_fetch <= pop_main;
      if (w_hold_load) r_hold <= data_demux_vc;
    end
  end

  // Arrival and release are mutually exclusive: nothing is fetched while holding.
  always_comb begin
    w_sel        = data_demux_vc[VC_BIT];
    w_hold_sel   = r_hold[VC_BIT];
    w_arr_full   = (w_sel == VC1) ? full_vc1 : full_vc0;
    w_hold_full  = (w_hold_sel == VC1) ? full_vc1 : full_vc0;
    w_stall      = r_fetch & w_arr_full;
    w_release    = (r_state == ST_HOLD) & ~w_hold_full;
    w_next_state = r_state;
    w_hold_load  = 1'b0;
    w_push0      = 1'b0;
    w_push1      = 1'b0;
    w_push_word  = '0;
    if (reset_L) begin
      if ((r_state == ST_RUN) && r_fetch) begin
        if (!w_arr_full) begin
          w_push0     = (w_sel == VC0);
          w_push1     = (w_sel == VC1);
          w_push_word = data_demux_vc;
        end else begin
          w_next_state = ST_HOLD;
          w_hold_load  = 1'b1;
        end
      end else if (w_release) begin
        w_push0      = (w_hold_sel == VC0);
        w_push1      = (w_hold_sel == VC1);
        w_push_word  = r_hold;
        w_next_state = ST_RUN;
      end
    end
  end

  assign pop_main      = reset_L & ((r_state == ST_RUN) | w_release) & ~fifo_empty_main
                         & ~pause_vc0 & ~pause_vc1 & ~w_stall;
  assign push_vc0      = w_push0;
  assign push_vc1      = w_push1;
  assign data_vc0      = w_push0 ? w_push_word : '0;
  assign data_vc1      = w_push1 ? w_push_word : '0;
  assign dispatch_idle = ~reset_L | ((r_state == ST_RUN) & ~r_fetch & fifo_empty_main);

`ifdef VC_DISPATCH_STATS_EN
  vc_dispatch_stats u_stats (
    .clk       (clk),
    .reset_L   (reset_L),
    .i_push_vc0(w_push0),
    .i_push_vc1(w_push1),
    .o_cnt_vc0 (cnt_vc0),
    .o_cnt_vc1 (cnt_vc1)
  );
`endif

endmodule

// File: tb/tb_vc_dispatch.sv
// Directed bench for vc_dispatch; inputs change 1ns after each rising edge and
// outputs are checked 1ns later. Counter checks need VC_DISPATCH_STATS_EN.
module tb_vc_dispatch;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       fifo_empty_main;
  logic [5:0] data_demux_vc;
  logic       pause_vc0, pause_vc1;
  logic       full_vc0, full_vc1;
  logic       pop_main;
  logic       push_vc0, push_vc1;
  logic [5:0] data_vc0, data_vc1;
  logic       dispatch_idle;
`ifdef VC_DISPATCH_STATS_EN
  logic [7:0] cnt_vc0, cnt_vc1;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vc_dispatch #(.DATA_SIZE(6), .VC_BIT(5)) dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .fifo_empty_main(fifo_empty_main),
    .data_demux_vc  (data_demux_vc),
    .pause_vc0      (pause_vc0),
    .pause_vc1      (pause_vc1),
    .full_vc0       (full_vc0),
    .full_vc1       (full_vc1),
    .pop_main       (pop_main),
    .push_vc0       (push_vc0),
    .push_vc1       (push_vc1),
    .data_vc0       (data_vc0),
    .data_vc1       (data_vc1),
    .dispatch_idle  (dispatch_idle)
`ifdef VC_DISPATCH_STATS_EN
    ,
    .cnt_vc0        (cnt_vc0),
    .cnt_vc1        (cnt_vc1)
`endif
  );

  // Advance to 1ns past the next rising edge, where new inputs are applied.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkPush(input string tag, input logic p0, input logic [5:0] d0,
                           input logic p1, input logic [5:0] d1);
    checkOutput({tag, "_push0"}, 32'(push_vc0), 32'(p0));
    checkOutput({tag, "_data0"}, 32'(data_vc0), 32'(d0));
    checkOutput({tag, "_push1"}, 32'(push_vc1), 32'(p1));
    checkOutput({tag, "_data1"}, 32'(data_vc1), 32'(d1));
  endtask

  initial begin
    reset_L = 1'b0; fifo_empty_main = 1'b0; data_demux_vc = '0;
    pause_vc0 = 1'b0; pause_vc1 = 1'b0; full_vc0 = 1'b0; full_vc1 = 1'b0;

    // Reset held 3 cycles with a non-empty main FIFO.
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("rst_pop", 32'(pop_main), 32'd0);
      checkOutput("rst_push0", 32'(push_vc0), 32'd0);
      checkOutput("rst_push1", 32'(push_vc1), 32'd0);
      checkOutput("rst_idle", 32'(dispatch_idle), 32'd1);
      applyStimulus();
    end
    reset_L = 1'b1;
    #1;
    checkOutput("rel_pop", 32'(pop_main), 32'd1);
    checkOutput("rel_idle", 32'(dispatch_idle), 32'd0);

    // Back-to-back words 0x25 (VC1) then 0x0A (VC0).
    applyStimulus();
    data_demux_vc = 6'h25;
    #1;
    checkPush("arr25", 1'b0, 6'h00, 1'b1, 6'h25);
    checkOutput("arr25_pop", 32'(pop_main), 32'd1);
    applyStimulus();
    data_demux_vc = 6'h0A; fifo_empty_main = 1'b1;
    #1;
    checkPush("arr0A", 1'b1, 6'h0A, 1'b0, 6'h00);
    checkOutput("arr0A_pop", 32'(pop_main), 32'd0);
    checkOutput("arr0A_idle", 32'(dispatch_idle), 32'd0);
    applyStimulus();
    data_demux_vc = 6'h00;
    #1;
    checkPush("drain", 1'b0, 6'h00, 1'b0, 6'h00);
    checkOutput("drain_idle", 32'(dispatch_idle), 32'd1);

    // Destination full at arrival: hold 0x25 until full_vc1 drops 3 cycles later.
    fifo_empty_main = 1'b0;
    #1;
    checkOutput("h_pop0", 32'(pop_main), 32'd1);
    applyStimulus();
    data_demux_vc = 6'h25; full_vc1 = 1'b1;
    #1;
    checkPush("h_arr", 1'b0, 6'h00, 1'b0, 6'h00);
    checkOutput("h_arr_pop", 32'(pop_main), 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      data_demux_vc = 6'h00;
      #1;
      checkPush("h_wait", 1'b0, 6'h00, 1'b0, 6'h00);
      checkOutput("h_wait_pop", 32'(pop_main), 32'd0);
      checkOutput("h_wait_idle", 32'(dispatch_idle), 32'd0);
    end
    applyStimulus();
    full_vc1 = 1'b0; fifo_empty_main = 1'b1;
    #1;
    checkPush("h_rel", 1'b0, 6'h00, 1'b1, 6'h25);
    applyStimulus();
    #1;
    checkPush("h_after", 1'b0, 6'h00, 1'b0, 6'h00);
    checkOutput("h_after_idle", 32'(dispatch_idle), 32'd1);

    // pause_vc0 blocks popping for 4 cycles.
    fifo_empty_main = 1'b0; pause_vc0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("pause_pop", 32'(pop_main), 32'd0);
      applyStimulus();
    end
    pause_vc0 = 1'b0;
    #1;
    checkOutput("unpause_pop", 32'(pop_main), 32'd1);

    // Hold 0x3F, then reset while holding: it must never be pushed.
    applyStimulus();
    data_demux_vc = 6'h3F; full_vc1 = 1'b1;
    #1;
    checkPush("h3f_arr", 1'b0, 6'h00, 1'b0, 6'h00);
    applyStimulus();
    data_demux_vc = 6'h00;
    #1;
    checkPush("h3f_wait", 1'b0, 6'h00, 1'b0, 6'h00);
    reset_L = 1'b0; full_vc1 = 1'b0; fifo_empty_main = 1'b1;
    #1;
    checkPush("h3f_rst", 1'b0, 6'h00, 1'b0, 6'h00);
    checkOutput("h3f_rst_idle", 32'(dispatch_idle), 32'd1);
    applyStimulus();
    reset_L = 1'b1;
    #1;
    checkPush("h3f_post", 1'b0, 6'h00, 1'b0, 6'h00);
    checkOutput("h3f_post_idle", 32'(dispatch_idle), 32'd1);
    checkOutput("h3f_post_pop", 32'(pop_main), 32'd0);
    applyStimulus();
    #1;
    checkPush("h3f_post2", 1'b0, 6'h00, 1'b0, 6'h00);

`ifdef VC_DISPATCH_STATS_EN
    // 300 words to VC0: counter saturates, VC1 count stays cleared.
    fifo_empty_main = 1'b0; data_demux_vc = 6'h05;
    for (int i = 0; i < 301; i++) applyStimulus();
    fifo_empty_main = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("cnt_vc0", 32'(cnt_vc0), 32'hFF);
    checkOutput("cnt_vc1", 32'(cnt_vc1), 32'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vc_dispatch.md
# vc_dispatch

- Stage directly downstream of the main FIFO.
- Pops the main FIFO whenever it is non-empty and both virtual-channel FIFOs have headroom.
- Steers each returned word to VC0 or VC1 by one class bit of the word.
- Absorbs late VC back-pressure in a single-entry hold register, so no word is ever dropped or duplicated.

## Interface
Parameters:
- DATA_SIZE, 6, word width; matches the main FIFO data width
- VC_BIT, DATA_SIZE-1, index of the class bit (0 → VC0, 1 → VC1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_L  in  1  synchronous, active-low reset
- fifo_empty_main  in  1  main FIFO empty flag
- data_demux_vc  in  DATA_SIZE  main FIFO registered read data; valid the cycle after pop_main
- pause_vc0, pause_vc1  in  1 each  VC FIFO almost-full
- full_vc0, full_vc1  in  1 each  VC FIFO full
- pop_main  out  1  pop request to main FIFO
- push_vc0, push_vc1  out  1 each  push strobes
- data_vc0, data_vc1  out  DATA_SIZE each  dispatched word; 0 when the matching push is low
- dispatch_idle  out  1  no word in flight or held, and main FIFO empty

## Operation
- Internal state:
  - fsm state: RUN or HOLD
  - fetch_q: pop issued last cycle
  - hold_q: held word, DATA_SIZE wide
- Arrival:
  - Applies when fetch_q=1.
  - Word w = data_demux_vc; sel = w[VC_BIT].
  - If full_vc[sel]=0: push_vc[sel]=1, data_vc[sel]=w.
  - Otherwise: hold_q ← w, state ← HOLD, no push.
- Pop rule: pop_main = reset_L & (state==RUN) & ~fifo_empty_main & ~pause_vc0 & ~pause_vc1 & ~stall.
  - stall = fetch_q & full_vc[sel].
  - pop_main is combinational.
  - fetch_q ← pop_main.
- HOLD:
  - pop_main is 0.
  - When full_vc[hold_q[VC_BIT]]=0: push that VC with hold_q, state ← RUN.
  - pop_main may assert in that release cycle.
- Push exclusivity:
  - At most one of push_vc0 and push_vc1 is high in any cycle.
  - Arrival and HOLD release never coincide, because no pop happens in HOLD.
- dispatch_idle = (state==RUN) & ~fetch_q & fifo_empty_main.
- Reset (reset_L=0 at an edge):
  - state ← RUN, fetch_q ← 0, hold_q ← 0.
  - While reset_L=0: pop_main=0, push_vc0=push_vc1=0, data_vc0=data_vc1=0, dispatch_idle=1.
  - A word in flight or held when reset asserts is discarded, since the main FIFO is reset on the same edge.

## Timing
- Latency from pop_main to push is 1 cycle (arrival path) when the destination is not full.
- Throughput is one word per cycle while the main FIFO is non-empty and neither VC is paused.
- A pause that asserts in the cycle after a pop does not block that arrival; only full does.
- HOLD lasts at least 1 cycle; release occurs in the first cycle the destination's full is low.
- Boundary cases:
  - fifo_empty_main rising while fetch_q=1: the in-flight word is still dispatched.
  - Both pauses low but the destination full at arrival: the word goes to HOLD; the next pop waits.

## Configuration
- Macro VC_DISPATCH_STATS_EN.
- When defined:
  - Adds outputs cnt_vc0 and cnt_vc1, 8 bits each, saturating at 8'hFF.
  - Each increments on its push strobe.
  - Both clear on reset.
- When undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package vc_pkg holds:
  - State encoding ST_RUN=1'b0, ST_HOLD=1'b1.
  - VC index constants VC0=0, VC1=1.
  - STATS_W=8.
- One sub-module: vc_dispatch_stats, two saturating counters, instantiated only under VC_DISPATCH_STATS_EN.

## Test plan
- Reset held 3 cycles with fifo_empty_main=0:
  - pop_main=0, both pushes 0, dispatch_idle=1.
  - After release: pop_main=1 in the first cycle.
- Main FIFO returns 6'h25 then 6'h0A back-to-back, no pause:
  - push_vc1 with 6'h25 in cycle N+1.
  - push_vc0 with 6'h0A in cycle N+2.
- full_vc1=1 when 6'h25 arrives:
  - Enters HOLD; pop_main=0.
  - full_vc1 drops 3 cycles later: push_vc1 with 6'h25 that cycle, state returns to RUN.
- pause_vc0=1 for 4 cycles with the main FIFO non-empty: pop_main=0 for all 4 cycles, then resumes.
- reset_L=0 while in HOLD with 6'h3F held: no push follows; after release, dispatch_idle=1 when the main FIFO is empty.
- VC_DISPATCH_STATS_EN, 300 words to VC0: cnt_vc0=8'hFF, cnt_vc1=0.
